// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the RAW hazard detector of the 5-stage mips core.
// Holds the register-address width, the $0 address, the default depth and the scoreboard slot type.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
    localparam int HAZ_DEPTH = 2;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
    } sb_slot_t;

    function automatic logic slot_match(input sb_slot_t slot, input logic [REG_ADDR_W-1:0] addr);
        return slot.valid && (slot.addr == addr);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sb.sv
// Shift-register scoreboard of in-flight destination registers (slot 0 = EX, last slot = oldest).
// Offers two lookup ports; a lookup of $0 never hits.
module hazard_ctrl_sb
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = HAZ_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bubble_i,
    input  logic                  push_wreg_i,
    input  logic [REG_ADDR_W-1:0] push_addr_i,
    input  logic [REG_ADDR_W-1:0] addr1_i,
    input  logic [REG_ADDR_W-1:0] addr2_i,
    output logic                  hit1_o,
    output logic                  hit2_o
);

    sb_slot_t slots_q [DEPTH];
    sb_slot_t push_d;

    always_comb begin
        push_d = '0;
        if (!bubble_i) begin
            push_d.valid = push_wreg_i && (push_addr_i != NOP_REG_ADDR);
            push_d.addr  = push_addr_i;
        end
    end

    // A stalled instruction is held in ID, so a bubble enters EX in its place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slots_q[i] <= slots_q[i-1];
            end
            slots_q[0] <= push_d;
        end
    end

    always_comb begin
        hit1_o = 1'b0;
        hit2_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1_o = hit1_o | slot_match(slots_q[i], addr1_i);
            hit2_o = hit2_o | slot_match(slots_q[i], addr2_i);
        end
        hit1_o = hit1_o && (addr1_i != NOP_REG_ADDR);
        hit2_o = hit2_o && (addr2_i != NOP_REG_ADDR);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// RAW hazard detector and stall generator for the forwarding-less 5-stage mips core.
// Drives bbl combinationally from the scoreboard and keeps saturating stall statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = HAZ_DEPTH,
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exp_read1,
    input  logic [REG_ADDR_W-1:0] exp_addr1,
    input  logic                  exp_read2,
    input  logic [REG_ADDR_W-1:0] exp_addr2,
    input  logic [REG_ADDR_W-1:0] tar_addr,
    input  logic                  tar_wreg,
    output logic                  bbl,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      hazard_cnt
);

    logic             hit1;
    logic             hit2;
    logic             bbl_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] hazard_cnt_q;
    logic [CNT_W-1:0] hazard_cnt_d;

    hazard_ctrl_sb #(
        .DEPTH(DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .bubble_i   (bbl),
        .push_wreg_i(tar_wreg),
        .push_addr_i(tar_addr),
        .addr1_i    (exp_addr1),
        .addr2_i    (exp_addr2),
        .hit1_o     (hit1),
        .hit2_o     (hit2)
    );

    // Reset gates first so X on the read strobes during reset cannot reach bbl.
    assign bbl = !rst && ((exp_read1 && hit1) || (exp_read2 && hit2));

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        hazard_cnt_d = hazard_cnt_q;
        if (bbl && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bbl && !bbl_q && (hazard_cnt_q != '1)) begin
            hazard_cnt_d = hazard_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bbl_q        <= 1'b0;
            stall_cnt_q  <= '0;
            hazard_cnt_q <= '0;
        end else begin
            bbl_q        <= bbl;
            stall_cnt_q  <= stall_cnt_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign hazard_cnt = hazard_cnt_q;

endmodule
